// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// States, owner encoding and the fixed fields driven for instruction fetch.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  // Instruction fetch is always a full-word read.
  localparam logic IF_WE         = 1'b0;
  localparam logic IF_BE_FILL    = 1'b1;
  localparam logic IF_WDATA_FILL = 1'b0;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between IF and LSU with an LSU streak limit that
// guarantees IF progress when both keep requesting.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   i_if_req,
  input  logic   i_lsu_req,
  input  logic   i_if_gnt,
  input  logic   i_lsu_gnt,
  output owner_e o_winner
);

  localparam int unsigned SW = $clog2(MAX_LSU_STREAK + 1);

  logic [SW-1:0] r_streak;
  logic          w_streak_full;

  assign w_streak_full = (r_streak == SW'(MAX_LSU_STREAK));

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    o_winner = OWNER_IF;
    if (i_lsu_req && !(i_if_req && w_streak_full)) begin
      o_winner = OWNER_LSU;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_streak <= '0;
    end else if (i_lsu_gnt) begin
      if (!i_if_req) begin
        r_streak <= '0;
      end else if (!w_streak_full) begin
        r_streak <= r_streak + SW'(1);
      end
    end else if (i_if_gnt) begin
      r_streak <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// Optional conflict counter enabled by defining MEM_PORT_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                lsu_req_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef MEM_PORT_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         conflict_cnt_o
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e r_state;
  state_e w_state_nxt;
  owner_e r_owner;
  owner_e w_owner_nxt;
  owner_e w_winner;
  owner_e w_sel;
  logic   w_arb_point;
  logic   w_req;
  logic   w_if_gnt;
  logic   w_lsu_gnt;

  // Reset gates the arbitration point so nothing is presented while rst_ni is low.
  assign w_arb_point = rst_ni && ((r_state == IDLE) || ((r_state == DATA) && mem_rvalid_i));
  assign w_sel       = w_arb_point ? w_winner : r_owner;
  assign w_req       = (w_arb_point && (if_req_i || lsu_req_i)) || (r_state == ADDR);
  assign w_if_gnt    = mem_gnt_i && w_req && (w_sel == OWNER_IF);
  assign w_lsu_gnt   = mem_gnt_i && w_req && (w_sel == OWNER_LSU);

  mem_arb_prio #(
    .MAX_LSU_STREAK(MAX_LSU_STREAK)
  ) u_prio (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_if_req (if_req_i),
    .i_lsu_req(lsu_req_i),
    .i_if_gnt (w_if_gnt),
    .i_lsu_gnt(w_lsu_gnt),
    .o_winner (w_winner)
  );

  always_comb begin
    mem_req_o   = w_req;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (w_req) begin
      if (w_sel == OWNER_LSU) begin
        mem_addr_o  = lsu_addr_i;
        mem_we_o    = lsu_we_i;
        mem_be_o    = lsu_be_i;
        mem_wdata_o = lsu_wdata_i;
      end else begin
        mem_addr_o  = if_addr_i;
        mem_we_o    = IF_WE;
        mem_be_o    = {BE_W{IF_BE_FILL}};
        mem_wdata_o = {DATA_W{IF_WDATA_FILL}};
      end
    end
  end

  assign if_gnt_o     = w_if_gnt;
  assign lsu_gnt_o    = w_lsu_gnt;
  assign if_rvalid_o  = (r_state == DATA) && mem_rvalid_i && (r_owner == OWNER_IF);
  assign lsu_rvalid_o = (r_state == DATA) && mem_rvalid_i && (r_owner == OWNER_LSU);
  assign if_rdata_o   = mem_rdata_i;
  assign lsu_rdata_o  = mem_rdata_i;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    if (w_arb_point) begin
      if (w_req) begin
        w_owner_nxt = w_winner;
        w_state_nxt = mem_gnt_i ? DATA : ADDR;
      end else begin
        w_state_nxt = IDLE;
      end
    end else if ((r_state == ADDR) && mem_gnt_i) begin
      w_state_nxt = DATA;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= OWNER_IF;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

`ifdef MEM_PORT_ARB_PERF_CNT_EN
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_conflict_cnt <= '0;
    end else if (w_arb_point && if_req_i && lsu_req_i) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i = 1'b0;
  logic [31:0] lsu_addr_i = '0;
  logic        lsu_we_i = 1'b0;
  logic [3:0]  lsu_be_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
`ifdef MEM_PORT_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_o;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LSU_STREAK(MAXS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
    .lsu_be_i(lsu_be_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef MEM_PORT_ARB_PERF_CNT_EN
    , .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  // Reference model: one outstanding transaction (owner -1 = none, 0 = IF, 1 = LSU).
  int           m_owner;
  bit           m_granted;
  int           m_streak;
  logic [31:0]  m_conf;
  int           e_pick;
  bit           e_can_issue;
  bit           e_done;
  logic [137:0] exp_vec;

  function automatic logic [137:0] obs_vec();
    return {mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, if_gnt_o, lsu_gnt_o,
            if_rvalid_o, lsu_rvalid_o, if_rdata_o, lsu_rdata_o};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_granted = 0; m_streak = 0; m_conf = '0;
  endtask

  task automatic model_eval();
    logic [31:0] a, wd;
    logic        we;
    logic [3:0]  be;
    e_can_issue = rst_ni && ((m_owner < 0) || (m_granted && mem_rvalid_i));
    e_done      = rst_ni && (m_owner >= 0) && m_granted && mem_rvalid_i;
    e_pick      = -1;
    if (e_can_issue) begin
      if (lsu_req_i && !(if_req_i && m_streak >= MAXS)) e_pick = 1;
      else if (if_req_i) e_pick = 0;
    end else if (rst_ni && m_owner >= 0 && !m_granted) begin
      e_pick = m_owner;
    end
    a = '0; we = 1'b0; be = '0; wd = '0;
    if (e_pick == 1) begin
      a = lsu_addr_i; we = lsu_we_i; be = lsu_be_i; wd = lsu_wdata_i;
    end else if (e_pick == 0) begin
      a = if_addr_i; be = 4'hF;
    end
    exp_vec = {e_pick >= 0, a, we, be, wd, (e_pick == 0) && mem_gnt_i, (e_pick == 1) && mem_gnt_i,
               e_done && m_owner == 0, e_done && m_owner == 1, mem_rdata_i, mem_rdata_i};
  endtask

  task automatic model_update();
    if (e_can_issue && if_req_i && lsu_req_i) m_conf = m_conf + 32'd1;
    if (e_done) m_owner = -1;
    if (e_pick >= 0) begin
      if (e_can_issue) begin
        m_owner = e_pick; m_granted = mem_gnt_i;
      end else if (mem_gnt_i) begin
        m_granted = 1;
      end
      if (mem_gnt_i) m_streak = (e_pick == 1 && if_req_i) ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
    end
  endtask

  task automatic cyc_begin();
    @(negedge clk_i);
    model_eval();
  endtask

  task automatic cyc_end();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0; model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    if_req_i = 1; lsu_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = '0;
    #12;
    total++;
    if (obs_vec() !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs_vec()); end
`ifdef MEM_PORT_ARB_PERF_CNT_EN
    total++;
    if (conflict_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_conflict_cnt: got %0d want 0", conflict_cnt_o); end
`endif
    if_req_i = 0; lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_if_only();
    bit [0:3] t_req = 4'b1000, t_gnt = 4'b1000, t_rv = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      if_req_i = t_req[i]; if_addr_i = 32'h100; mem_gnt_i = t_gnt[i]; mem_rvalid_i = t_rv[i];
      mem_rdata_i = t_rv[i] ? 32'hDEADBEEF : '0;
      cyc_begin();
      total++;
      if (obs_vec() !== exp_vec) begin bad++; $display("FAIL if_only c%0d: got %h want %h", i, obs_vec(), exp_vec); end
      if (i == 0) begin
        total++;
        if (if_gnt_o !== 1'b1) begin bad++; $display("FAIL if_only_gnt: got %b want 1", if_gnt_o); end
      end
      if (i == 2) begin
        total++;
        if ({if_rvalid_o, lsu_rvalid_o, if_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
          bad++; $display("FAIL if_only_resp: got %b%b %h want 10 deadbeef", if_rvalid_o, lsu_rvalid_o, if_rdata_o);
        end
      end
      cyc_end();
    end
    mem_rdata_i = '0;
  endtask

  task automatic test_simultaneous();
    bit [0:3] t_if = 4'b1100, t_lsu = 4'b1000, t_gnt = 4'b1100, t_rv = 4'b0110;
    bit [0:3] t_igt = 4'b0100, t_lgt = 4'b1000;
    if_addr_i = 32'h400; lsu_addr_i = 32'h200; lsu_we_i = 1; lsu_be_i = 4'b0011; lsu_wdata_i = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      if_req_i = t_if[i]; lsu_req_i = t_lsu[i]; mem_gnt_i = t_gnt[i]; mem_rvalid_i = t_rv[i];
      cyc_begin();
      total++;
      if (obs_vec() !== exp_vec) begin bad++; $display("FAIL simul c%0d: got %h want %h", i, obs_vec(), exp_vec); end
      total++;
      if ({if_gnt_o, lsu_gnt_o} !== {t_igt[i], t_lgt[i]}) begin
        bad++; $display("FAIL simul_gnt c%0d: got if=%b lsu=%b want if=%b lsu=%b", i, if_gnt_o, lsu_gnt_o, t_igt[i], t_lgt[i]);
      end
      if (i == 0) begin
        total++;
        if ({mem_we_o, mem_be_o, mem_wdata_o} !== {1'b1, 4'b0011, 32'h1234}) begin
          bad++; $display("FAIL simul_store: got we=%b be=%b wd=%h want 1 0011 1234", mem_we_o, mem_be_o, mem_wdata_o);
        end
      end
      cyc_end();
    end
    lsu_we_i = 0;
  endtask

  task automatic test_starvation();
    bit [0:5] t_lgt = 6'b111101;
    pulse_reset();
    if_req_i = 1; lsu_req_i = 1; if_addr_i = 32'h800; lsu_addr_i = 32'h900; lsu_we_i = 0; lsu_be_i = 4'hF;
    mem_gnt_i = 1; mem_rvalid_i = 1;
    for (int i = 0; i < 6; i++) begin
      cyc_begin();
      total++;
      if (obs_vec() !== exp_vec) begin bad++; $display("FAIL starve c%0d: got %h want %h", i, obs_vec(), exp_vec); end
      total++;
      if ({lsu_gnt_o, if_gnt_o} !== {t_lgt[i], ~t_lgt[i]}) begin
        bad++; $display("FAIL starve_order c%0d: got lsu=%b if=%b want lsu=%b", i, lsu_gnt_o, if_gnt_o, t_lgt[i]);
      end
`ifdef MEM_PORT_ARB_PERF_CNT_EN
      if (i == 5) begin
        total++;
        if (conflict_cnt_o !== 32'd5) begin bad++; $display("FAIL conflict_cnt: got %0d want 5", conflict_cnt_o); end
      end
`endif
      cyc_end();
    end
    if_req_i = 0; lsu_req_i = 0; mem_gnt_i = 0;
    cyc_begin();
    total++;
    if (obs_vec() !== exp_vec) begin bad++; $display("FAIL starve_drain: got %h want %h", obs_vec(), exp_vec); end
    cyc_end();
    mem_rvalid_i = 0;
  endtask

  task automatic test_grant_stall();
    bit [0:6] t_lsu = 7'b1111000, t_if = 7'b0111110, t_gnt = 7'b0001010, t_rv = 7'b0000011;
    bit [0:6] t_igt = 7'b0000010;
    lsu_addr_i = 32'h300; lsu_we_i = 0; if_addr_i = 32'h500;
    for (int i = 0; i < 7; i++) begin
      lsu_req_i = t_lsu[i]; if_req_i = t_if[i]; mem_gnt_i = t_gnt[i]; mem_rvalid_i = t_rv[i];
      cyc_begin();
      total++;
      if (obs_vec() !== exp_vec) begin bad++; $display("FAIL stall c%0d: got %h want %h", i, obs_vec(), exp_vec); end
      total++;
      if (if_gnt_o !== t_igt[i]) begin bad++; $display("FAIL stall_if_gnt c%0d: got %b want %b", i, if_gnt_o, t_igt[i]); end
      if (i < 4) begin
        total++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h300}) begin
          bad++; $display("FAIL stall_addr c%0d: got req=%b addr=%h want 1 300", i, mem_req_o, mem_addr_o);
        end
      end
      cyc_end();
    end
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  task automatic test_back_to_back();
    if_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    for (int i = 0; i < 6; i++) begin
      if_addr_i = 32'h1000 + 32'(i * 4);
      mem_rdata_i = 32'hA000 + 32'(i);
      cyc_begin();
      total++;
      if (obs_vec() !== exp_vec) begin bad++; $display("FAIL b2b c%0d: got %h want %h", i, obs_vec(), exp_vec); end
      total++;
      if ({mem_req_o, if_gnt_o} !== 2'b11) begin bad++; $display("FAIL b2b_issue c%0d: got req=%b gnt=%b want 11", i, mem_req_o, if_gnt_o); end
      cyc_end();
    end
    if_req_i = 0; mem_gnt_i = 0;
    cyc_begin();
    total++;
    if (obs_vec() !== exp_vec) begin bad++; $display("FAIL b2b_drain: got %h want %h", obs_vec(), exp_vec); end
    cyc_end();
    mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic test_reset_mid_op();
    lsu_req_i = 1; lsu_addr_i = 32'h600; lsu_we_i = 0; mem_gnt_i = 1;
    cyc_begin();
    cyc_end();
    lsu_req_i = 0; mem_gnt_i = 0;
    @(negedge clk_i); #2;
    if_req_i = 1; lsu_req_i = 1; mem_gnt_i = 1; mem_rdata_i = '0;
    rst_ni = 1'b0; model_reset();
    #1;
    total++;
    if (obs_vec() !== '0) begin bad++; $display("FAIL midrst_outputs: got %h want 0", obs_vec()); end
    @(posedge clk_i); #1;
    if_req_i = 0; lsu_req_i = 0; mem_gnt_i = 0;
    rst_ni = 1'b1;
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
    cyc_begin();
    total++;
    if (obs_vec() !== exp_vec) begin bad++; $display("FAIL midrst_stray c%0d: got %h want %h", 0, obs_vec(), exp_vec); end
    total++;
    if ({if_rvalid_o, lsu_rvalid_o} !== 2'b00) begin bad++; $display("FAIL midrst_rvalid: got %b%b want 00", if_rvalid_o, lsu_rvalid_o); end
    cyc_end();
    mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic test_random();
    bit if_pend = 0, lsu_pend = 0;
    for (int i = 0; i < 500; i++) begin
      if (!if_pend && ($urandom % 3 == 0)) begin
        if_pend = 1; if_addr_i = $urandom;
      end
      if (!lsu_pend && ($urandom % 3 == 0)) begin
        lsu_pend = 1; lsu_addr_i = $urandom; lsu_we_i = 1'($urandom);
        lsu_be_i = 4'($urandom); lsu_wdata_i = $urandom;
      end
      if_req_i = if_pend; lsu_req_i = lsu_pend;
      mem_gnt_i = ($urandom % 4 != 0); mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
      cyc_begin();
      total++;
      if (obs_vec() !== exp_vec) begin bad++; $display("FAIL random c%0d: got %h want %h", i, obs_vec(), exp_vec); end
`ifdef MEM_PORT_ARB_PERF_CNT_EN
      total++;
      if (conflict_cnt_o !== m_conf) begin bad++; $display("FAIL random_cnt c%0d: got %0d want %0d", i, conflict_cnt_o, m_conf); end
`endif
      if (e_pick == 0 && mem_gnt_i) if_pend = 0;
      if (e_pick == 1 && mem_gnt_i) lsu_pend = 0;
      cyc_end();
    end
    if_req_i = 0; lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_if_only();
    test_simultaneous();
    test_starvation();
    test_grant_stall();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
